keypad_scan_fifo: RTL and testbench
===================================

Name: keypad_scan_fifo

Overview:
Parametrised matrix-keypad controller and successor to keypad_peripheral. It scans an arbitrary NUM_ROWS x NUM_COLS matrix and debounces every key independently. Debounced press events are queued in a show-ahead FIFO with a valid/ready pop handshake, so the CPU bus or display logic can consume keys without losing them. It also keeps the hex0/hex1 seven-segment readout of the last accepted key.

Parameters:
NUM_ROWS, 4, number of row sense inputs
NUM_COLS, 4, number of column drive outputs
SCAN_DIV, 1000, settle cycles per column before sampling (>=1)
DEBOUNCE_SCANS, 4, consecutive agreeing samples needed to change a key's state (1..15)
FIFO_DEPTH, 8, key-event queue depth (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cols  out  NUM_COLS  one-hot active-high column drive
rows  in  NUM_ROWS  active-high row sense, asynchronous to clk
key_valid  out  1  FIFO head valid
key_code  out  KEY_W  head key code = row*NUM_COLS+col; KEY_W=max(1,clog2(NUM_ROWS*NUM_COLS))
key_ready  in  1  consumer pop; pop occurs when key_valid && key_ready
fifo_count  out  clog2(FIFO_DEPTH)+1  entries queued
overflow  out  1  sticky: press event dropped because FIFO was full
clr_ovf  in  1  clears overflow
hex0  out  7  active-low segments (gfedcba), last accepted code bits[3:0]
hex1  out  7  active-low segments, last accepted code bits[7:4] (zero-extended)

Behaviour:
- Reset values: cols=0, key_valid=0, key_code=0, fifo_count=0, overflow=0, all debounce integrators=0, all keys released, last-key register=0, hex0=hex1=7'b1000000 ("0").
- rows pass through a 2-flop synchroniser before use.
- Scan FSM states: DRIVE -> SAMPLE -> EVAL -> NEXT -> DRIVE. It enters DRIVE with col=0 on the first cycle after rst.
  - DRIVE: cols=one-hot(col), held for SCAN_DIV cycles.
  - SAMPLE: 1 cycle; latches the synchronised rows.
  - EVAL: NUM_ROWS cycles; row r handled in cycle r.
  - NEXT: 1 cycle; col wraps NUM_COLS-1 -> 0.
  - cols stays asserted through SAMPLE and EVAL, and is 0 only in NEXT.
  - Column period T=SCAN_DIV+NUM_ROWS+2; full scan = NUM_COLS*T.
- Per-key integrator: +1 if sampled high (saturates at DEBOUNCE_SCANS), -1 if low (saturates at 0).
  - Released key becomes pressed when the integrator reaches DEBOUNCE_SCANS. This generates exactly one press event.
  - Pressed key becomes released when the integrator reaches 0. No event is generated.
  - Holding a key never re-queues it.
- Press event is a push into the FIFO in that EVAL cycle.
  - key_valid/key_code reflect the push on the next cycle if the FIFO was empty.
  - The last-key register, hex0 and hex1 update on that same next cycle.
- Simultaneous presses are queued in scan order: column ascending, then row ascending within a column. At most one push per cycle.
- FIFO full with push and no pop: event dropped, overflow<=1, last-key/hex not updated, key still marked pressed.
- Full with push and pop in the same cycle: both happen, count unchanged, no overflow.
- Empty: key_valid=0, key_code holds the last-popped value, and key_ready is ignored.
- clr_ovf in the same cycle as a drop: overflow stays 1 (set wins).
- rst mid-scan or mid-debounce: everything returns to reset values on the next edge, the FIFO is flushed, and keys still held must re-debounce to produce an event.

Decomposition:
- Shared package/include kp_pkg holds:
  - KEY_W and count-width clog2 helper functions
  - FSM state encodings
  - the 16-entry active-low seven-segment hex font constant (shared with other display blocks)
- Natural sub-module: kp_sync_fifo, a show-ahead synchronous FIFO with count, parametrised by WIDTH/DEPTH. The scan/debounce FSM stays in the top module.

Test Plan:
All scenarios use NUM_ROWS=4, NUM_COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4 (T=10, scan=40).
1. Reset sequence -> after rst deassert, cols cycles 0001,0010,0100,1000 with the specified T. Outputs key_valid=0, hex0=hex1=7'b1000000.
2. Hold rows=0001 whenever cols=0010 (key r0c1) for 200 cycles -> exactly one event, key_code=1, hex0="1", fifo_count=1. Release for 3 scans, press again -> second event.
3. Bouncing input (press glitches shorter than 3 consecutive samples) -> no event. Stable press -> single event.
4. Keys r3c1 and r0c2 pressed together -> events 13 then 2. Pop with key_ready=1 gives 13, then 2, then key_valid=0.
5. With key_ready=0, press 5 distinct keys -> fifo_count=4, overflow=1, fifth dropped. Pulse clr_ovf -> overflow=0.
6. rst asserted mid-EVAL with 2 queued events and a key held -> FIFO empty and cols=0. The held key produces a fresh event 3 scans after reset.

Source files
------------

// File: rtl/kp_pkg.sv
// kp_pkg: shared keypad widths, scan FSM encoding and seven-segment font
// Contents:
//   scan_state_t  scan FSM states (DRIVE, SAMPLE, EVAL, NEXT)
//   clog2_min1    ceil(log2(n)) clamped to at least 1 bit
//   key_w         key code width for a rows x cols matrix
//   count_w       occupancy counter width for a FIFO of given depth
//   HEX_FONT      active-low gfedcba glyphs for 0..F, indexed by nibble
package kp_pkg;

    typedef enum logic [1:0] {
        S_DRIVE,
        S_SAMPLE,
        S_EVAL,
        S_NEXT
    } scan_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int key_w(input int rows, input int cols);
        return clog2_min1(rows * cols);
    endfunction

    // One extra bit so a completely full FIFO is distinguishable from empty
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/kp_sync_fifo.sv
// kp_sync_fifo: show-ahead synchronous FIFO with occupancy count
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push/din  write request and data; ignored when full unless popping
//   pop       read request; ignored when empty
//   valid     head entry present
//   dout      head entry, or the most recently popped entry when empty
//   full      no free slot
//   count     entries held
module kp_sync_fifo
    import kp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic                      valid,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic [count_w(DEPTH)-1:0] count
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH-1:0] hold;
    logic             do_push;
    logic             do_pop;

    assign valid   = count != '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : hold;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                hold   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix keypad scanner with per-key debounce and key-event FIFO
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   cols        one-hot active-high column drive, 0 between columns
//   rows        active-high row sense, asynchronous
//   key_valid   FIFO head valid
//   key_code    FIFO head code row*NUM_COLS+col (last popped when empty)
//   key_ready   consumer pop strobe
//   fifo_count  queued events
//   overflow    sticky, a press was dropped on a full FIFO
//   clr_ovf     clears overflow (a simultaneous drop wins)
//   hex0, hex1  active-low digits of the last accepted code, low/high nibble
module keypad_scan_fifo
    import kp_pkg::*;
#(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [NUM_COLS-1:0]                  cols,
    input  logic [NUM_ROWS-1:0]                  rows,
    output logic                                 key_valid,
    output logic [key_w(NUM_ROWS, NUM_COLS)-1:0] key_code,
    input  logic                                 key_ready,
    output logic [count_w(FIFO_DEPTH)-1:0]       fifo_count,
    output logic                                 overflow,
    input  logic                                 clr_ovf,
    output logic [6:0]                           hex0,
    output logic [6:0]                           hex1
);

    localparam int NKEYS = NUM_ROWS * NUM_COLS;
    localparam int KEY_W = key_w(NUM_ROWS, NUM_COLS);
    localparam int COL_W = clog2_min1(NUM_COLS);
    localparam int ROW_W = clog2_min1(NUM_ROWS);
    localparam int TMR_W = clog2_min1((SCAN_DIV > NUM_ROWS) ? SCAN_DIV : NUM_ROWS);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [COL_W-1:0]    col;
    logic [COL_W-1:0]    col_nxt;
    logic [TMR_W-1:0]    tmr;
    logic [TMR_W-1:0]    tmr_nxt;
    logic [NUM_ROWS-1:0] rows_s1;
    logic [NUM_ROWS-1:0] rows_s2;
    logic [NUM_ROWS-1:0] samp;
    logic [3:0]          integ [NKEYS];
    logic [NKEYS-1:0]    pressed;
    logic [ROW_W-1:0]    row;
    logic [KEY_W-1:0]    key_idx;
    logic [3:0]          cur;
    logic [3:0]          integ_nxt;
    logic                eval;
    logic                push;
    logic                full;
    logic                accept;
    logic                drop;
    logic [7:0]          last_key;

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        tmr_nxt   = tmr + 1'b1;
        case (state)
            S_DRIVE: begin
                if (tmr == TMR_W'(SCAN_DIV - 1)) begin
                    state_nxt = S_SAMPLE;
                    tmr_nxt   = '0;
                end
            end
            S_SAMPLE: begin
                state_nxt = S_EVAL;
                tmr_nxt   = '0;
            end
            S_EVAL: begin
                if (tmr == TMR_W'(NUM_ROWS - 1)) begin
                    state_nxt = S_NEXT;
                    tmr_nxt   = '0;
                end
            end
            S_NEXT: begin
                state_nxt = S_DRIVE;
                tmr_nxt   = '0;
                col_nxt   = (col == COL_W'(NUM_COLS - 1)) ? '0 : col + 1'b1;
            end
            default: begin
                state_nxt = S_DRIVE;
                tmr_nxt   = '0;
            end
        endcase
    end

    assign cols = (state == S_NEXT) ? '0 : NUM_COLS'(1) << col;

    // In EVAL the timer doubles as the row index being integrated
    always_comb begin
        eval      = state == S_EVAL;
        row       = ROW_W'(tmr);
        key_idx   = KEY_W'(int'(row) * NUM_COLS + int'(col));
        cur       = integ[key_idx];
        integ_nxt = samp[row] ? ((cur == DB) ? cur : cur + 4'd1)
                              : ((cur == 4'd0) ? cur : cur - 4'd1);
        push      = eval && !pressed[key_idx] && integ_nxt == DB;
        accept    = push && (!full || (key_valid && key_ready));
        drop      = push && !accept;
    end

    // Reset parks the FSM in NEXT on the last column so cols reads 0 and the
    // first clock after reset wraps straight into DRIVE of column 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_NEXT;
            col      <= COL_W'(NUM_COLS - 1);
            tmr      <= '0;
            rows_s1  <= '0;
            rows_s2  <= '0;
            samp     <= '0;
            pressed  <= '0;
            overflow <= 1'b0;
            last_key <= '0;
            for (int i = 0; i < NKEYS; i++)
                integ[i] <= '0;
        end else begin
            state   <= state_nxt;
            col     <= col_nxt;
            tmr     <= tmr_nxt;
            rows_s1 <= rows;
            rows_s2 <= rows_s1;
            if (state == S_SAMPLE)
                samp <= rows_s2;
            // A dropped press still marks the key pressed so holding it never re-queues
            if (eval) begin
                integ[key_idx] <= integ_nxt;
                if (push)
                    pressed[key_idx] <= 1'b1;
                else if (integ_nxt == 4'd0)
                    pressed[key_idx] <= 1'b0;
            end
            if (accept)
                last_key <= 8'(key_idx);
            overflow <= drop | (overflow & ~clr_ovf);
        end
    end

    assign hex0 = HEX_FONT[last_key[3:0]];
    assign hex1 = HEX_FONT[last_key[7:4]];

    kp_sync_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (key_idx),
        .pop   (key_ready),
        .valid (key_valid),
        .dout  (key_code),
        .full  (full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo: keypad matrix + queue reference model, table and scenario checks
module tb_keypad_scan_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_ovf = 1'b0;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [15:0] phys = '0;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 0;

    always #5 clk = ~clk;

    keypad_scan_fifo #(
        .NUM_ROWS       (4),
        .NUM_COLS       (4),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cols       (cols),
        .rows       (rows),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .hex0       (hex0),
        .hex1       (hex1)
    );

    // Physical keypad: a closed key shorts its column drive onto its row
    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                rows[r] = rows[r] | (cols[c] & phys[r*4+c]);
    end

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: n_m counts clocks since reset; column period 10, scan 40.
    // Key (r,c) is judged on clock 10*c + r + 7 of each scan.
    int n_m = 0;
    int integ [16];
    bit mpress [16];
    int q [$];
    bit m_ovf = 0;
    int last_key = 0;
    int last_pop = 0;

    task automatic model_step();
        int  k;
        int  ph;
        bit  push;
        bit  pop;
        bit  drop;
        if (rst) begin
            n_m = 0;
            foreach (integ[i]) begin
                integ[i]  = 0;
                mpress[i] = 0;
            end
            q.delete();
            m_ovf    = 0;
            last_key = 0;
            last_pop = 0;
            return;
        end
        n_m++;
        push = 0;
        k    = 0;
        if (n_m >= 2) begin
            ph = (n_m - 2) % 10;
            if (ph >= 5 && ph <= 8) begin
                k = (ph - 5) * 4 + ((n_m - 2) / 10) % 4;
                integ[k] = phys[k] ? ((integ[k] < 3) ? integ[k] + 1 : 3)
                                   : ((integ[k] > 0) ? integ[k] - 1 : 0);
                if (!mpress[k] && integ[k] == 3) begin
                    mpress[k] = 1;
                    push = 1;
                end else if (mpress[k] && integ[k] == 0) begin
                    mpress[k] = 0;
                end
            end
        end
        pop  = q.size() > 0 && key_ready;
        drop = push && q.size() == 4 && !pop;
        if (pop)
            last_pop = q.pop_front();
        if (push && !drop) begin
            q.push_back(k);
            last_key = k;
        end
        if (drop)
            m_ovf = 1;
        else if (clr_ovf)
            m_ovf = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model
    initial forever begin
        logic [3:0]  ce;
        logic [26:0] got;
        logic [26:0] exp;
        @(negedge clk);
        if (!done) begin
            ce  = (n_m == 0 || (n_m - 1) % 10 == 9) ? 4'b0 : 4'(1 << (((n_m - 1) / 10) % 4));
            got = {cols, key_valid, key_code, fifo_count, overflow, hex0, hex1};
            exp = {ce, 1'(q.size() > 0), 4'((q.size() > 0) ? q[0] : last_pop), 3'(q.size()),
                   m_ovf, font[last_key % 16], font[last_key / 16]};
            check("model", 32'(got), 32'(exp));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        phys      = '0;
        key_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance to the next end-of-scan point, where phys may safely change
    task automatic wait_scan();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(n_m > 0 && n_m % 40 == 0) && g < 100);
        if (g >= 100)
            check("scan_align_timeout", 32'(g), 32'(0));
    endtask

    task automatic scans(input int k);
        repeat (k) wait_scan();
    endtask

    task automatic pop1();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
        logic [6:0] h0;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl = '{'{0, 0, 4'd0,  7'h40}, '{0, 1, 4'd1,  7'h79}, '{0, 2, 4'd2,  7'h24}, '{0, 3, 4'd3,  7'h30},
                '{1, 0, 4'd4,  7'h19}, '{1, 1, 4'd5,  7'h12}, '{1, 2, 4'd6,  7'h02}, '{1, 3, 4'd7,  7'h78},
                '{2, 0, 4'd8,  7'h00}, '{2, 1, 4'd9,  7'h10}, '{2, 2, 4'd10, 7'h08}, '{2, 3, 4'd11, 7'h03},
                '{3, 0, 4'd12, 7'h46}, '{3, 1, 4'd13, 7'h21}, '{3, 2, 4'd14, 7'h06}, '{3, 3, 4'd15, 7'h0E}};

        // Reset state and column sequence
        repeat (3) @(negedge clk);
        check("rst_cols", 32'(cols), 32'(0));
        check("rst_hex0", 32'(hex0), 32'(7'b1000000));
        check("rst_valid", 32'(key_valid), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("cols_c0", 32'(cols), 32'(4'b0001));
        repeat (9) @(negedge clk);
        check("cols_gap", 32'(cols), 32'(4'b0000));
        @(negedge clk);
        check("cols_c1", 32'(cols), 32'(4'b0010));
        repeat (10) @(negedge clk);
        check("cols_c2", 32'(cols), 32'(4'b0100));
        repeat (10) @(negedge clk);
        check("cols_c3", 32'(cols), 32'(4'b1000));
        repeat (10) @(negedge clk);
        check("cols_wrap", 32'(cols), 32'(4'b0001));
        check("hex1_idle", 32'(hex1), 32'(7'b1000000));

        // Single key held long, then release and re-press
        do_reset();
        phys = 16'h0002;
        scans(5);
        check("hold_count", 32'(fifo_count), 32'(1));
        check("hold_code", 32'(key_code), 32'(1));
        check("hold_hex0", 32'(hex0), 32'(7'b1111001));
        phys = '0;
        scans(3);
        check("release_no_event", 32'(fifo_count), 32'(1));
        phys = 16'h0002;
        scans(3);
        check("repress_count", 32'(fifo_count), 32'(2));
        pop1();
        check("repress_pop", 32'(fifo_count), 32'(1));

        // Bounce shorter than the debounce window
        do_reset();
        for (int i = 0; i < 8; i++) begin
            phys = (i % 4 < 2) ? 16'h0040 : 16'h0000;
            wait_scan();
        end
        check("bounce_none", 32'(fifo_count), 32'(0));
        phys = 16'h0040;
        scans(3);
        check("bounce_stable", 32'(fifo_count), 32'(1));
        check("bounce_code", 32'(key_code), 32'(6));

        // Simultaneous keys queue in scan order
        do_reset();
        phys = (16'h1 << 13) | (16'h1 << 2);
        scans(3);
        check("dual_count", 32'(fifo_count), 32'(2));
        check("dual_first", 32'(key_code), 32'(13));
        pop1();
        check("dual_second", 32'(key_code), 32'(2));
        pop1();
        check("dual_empty", 32'(key_valid), 32'(0));
        check("dual_hold", 32'(key_code), 32'(2));
        pop1();
        check("empty_pop_ign", 32'(fifo_count), 32'(0));
        scans(2);
        check("no_requeue", 32'(fifo_count), 32'(0));

        // Overflow: five keys, depth four
        do_reset();
        phys = 16'h8000 | 16'h0400 | 16'h0020 | 16'h0008 | 16'h0001;
        scans(3);
        check("ovf_count", 32'(fifo_count), 32'(4));
        check("ovf_flag", 32'(overflow), 32'(1));
        check("ovf_head", 32'(key_code), 32'(0));
        check("ovf_lastkey", 32'(hex0), 32'(7'b0110000));
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clear", 32'(overflow), 32'(0));

        // Reset during EVAL with events queued and keys held
        do_reset();
        phys = (16'h1 << 13) | (16'h1 << 2);
        scans(3);
        check("mid_pre", 32'(fifo_count), 32'(2));
        begin
            int g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!((n_m - 1) % 10 >= 5 && (n_m - 1) % 10 <= 8) && g < 20);
            check("eval_align", 32'(g < 20), 32'(1));
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_count", 32'(fifo_count), 32'(0));
        check("mid_rst_cols", 32'(cols), 32'(0));
        check("mid_rst_valid", 32'(key_valid), 32'(0));
        rst = 1'b0;
        scans(2);
        check("mid_redebounce", 32'(fifo_count), 32'(0));
        scans(1);
        check("mid_fresh", 32'(fifo_count), 32'(2));
        check("mid_fresh_code", 32'(key_code), 32'(13));

        // Table: every key alone gives its code and digit
        for (int i = 0; i < 16; i++) begin
            do_reset();
            phys = 16'h1 << (tbl[i].r * 4 + tbl[i].c);
            scans(3);
            check("tbl_code", 32'(key_code), 32'(tbl[i].code));
            check("tbl_hex0", 32'(hex0), 32'(tbl[i].h0));
            check("tbl_hex1", 32'(hex1), 32'(7'b1000000));
        end

        // Random key activity, pops and overflow clears against the model
        do_reset();
        for (int s = 0; s < 40; s++) begin
            phys = phys ^ 16'($urandom & $urandom & $urandom);
            for (int i = 0; i < 40; i++) begin
                key_ready = ($urandom_range(0, 2) == 0);
                clr_ovf   = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
        end
        key_ready = 1'b0;
        clr_ovf   = 1'b0;
        @(negedge clk);

        done = 1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
